// File: rtl/kb_event_fifo.sv
// kb_event_fifo: held-key level -> press/typematic events, FWFT FIFO to CPU.
// Define KB_BREAK_EVENT_EN to also queue release (break) events.
module kb_event_fifo #(
  parameter int unsigned DELAY_CYC  = 25000000,
  parameter int unsigned REPEAT_CYC = 12500000,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      ascii,
  input  logic [4:0]      flags,
  input  logic            rd_en,
  output logic [15:0]     rd_data,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    MAKE
  } st_t;

  st_t st, st_n;

  logic [7:0]      a_r;
  logic [7:0]      key_prev;
  logic [4:0]      f_r;
`ifdef KB_BREAK_EVENT_EN
  logic [4:0]      f_prev;
`endif
  logic [31:0]     tmr, tmr_n, lim;
  logic            push;
  logic [15:0]     ev;
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] ptr_one;
  logic [15:0]     mem [DEPTH];
  logic            full, pop_ok, push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      f_r      <= '0;
      key_prev <= '0;
    end else begin
      a_r      <= ascii;
      f_r      <= flags;
      key_prev <= a_r;
    end
  end

`ifdef KB_BREAK_EVENT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_prev <= '0;
    else        f_prev <= f_r;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      tmr <= '0;
    end else begin
      st  <= st_n;
      tmr <= tmr_n;
    end
  end

  assign lim = (st == REPEAT) ? REPEAT_CYC : DELAY_CYC;

  always_comb begin
    st_n  = st;
    tmr_n = tmr;
    push  = 1'b0;
    ev    = {3'b000, f_r, a_r};
    unique case (st)
      IDLE: begin
        if (a_r != 8'd0) begin
          push  = 1'b1;
          tmr_n = 32'd1;
          st_n  = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (a_r == 8'd0) begin
          st_n  = IDLE;
          tmr_n = '0;
`ifdef KB_BREAK_EVENT_EN
          push  = 1'b1;
          ev    = {1'b1, 2'b00, f_prev, key_prev};
`endif
        end else if (a_r != key_prev) begin
`ifdef KB_BREAK_EVENT_EN
          // old key breaks now, new key makes next cycle
          push  = 1'b1;
          ev    = {1'b1, 2'b00, f_prev, key_prev};
          tmr_n = '0;
          st_n  = MAKE;
`else
          push  = 1'b1;
          tmr_n = 32'd1;
          st_n  = DELAY;
`endif
        end else if (tmr == lim) begin
          push  = 1'b1;
          tmr_n = 32'd1;
          st_n  = REPEAT;
        end else begin
          tmr_n = tmr + 32'd1;
        end
      end
      MAKE: begin
        if (a_r == 8'd0) begin
          st_n  = IDLE;
          tmr_n = '0;
        end else begin
          push  = 1'b1;
          tmr_n = 32'd1;
          st_n  = DELAY;
        end
      end
      default: begin
        st_n  = IDLE;
        tmr_n = '0;
      end
    endcase
  end

  // count never exceeds DEPTH, so its MSB alone marks full
  assign count   = wr_ptr - rd_ptr;
  assign full    = count[ADDR_W];
  assign empty   = (count == '0);
  assign pop_ok  = rd_en & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign ptr_one = {{ADDR_W{1'b0}}, 1'b1};
  assign rd_data = empty ? 16'h0000
                         : mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_one;
      if (pop_ok)  rd_ptr <= rd_ptr + ptr_one;
      if (push & full & ~pop_ok) overflow <= 1'b1;
      else if (ovf_clr)          overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kb_event_fifo.sv
// tb_kb_event_fifo: directed checks of kb_event_fifo.
// Small timing: DELAY_CYC=10, REPEAT_CYC=4, ADDR_W=2.
module tb_kb_event_fifo;

`ifdef KB_BREAK_EVENT_EN
  localparam int BRK = 1;
`else
  localparam int BRK = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  ascii;
  logic [4:0]  flags;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;
  logic        ovf_clr;

  int errs;
  int checks;

  kb_event_fifo #(
    .DELAY_CYC (10),
    .REPEAT_CYC(4),
    .ADDR_W    (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ascii   (ascii),
    .flags   (flags),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .count   (count),
    .overflow(overflow),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && !empty; i++) pop();
  endtask

  initial begin
    errs    = 0;
    checks  = 0;
    clk     = 1'b0;
    rst_n   = 1'b0;
    ascii   = 8'h00;
    flags   = 5'h00;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(rd_data), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // single press, pop strobe in the push cycle while empty
    ascii = 8'h61;
    flags = 5'h01;
    step(1);
    chk("sp_empty_e1", 32'(empty), 32'd1);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk("sp_empty_e2", 32'(empty), 32'd0);
    chk("sp_count", 32'(count), 32'd1);
    chk("sp_data", 32'(rd_data), 32'h0161);
    step(3);
    ascii = 8'h00;
    step(3);
    chk("sp_count_rel", 32'(count), 32'(1 + BRK));
    chk("sp_data_rel", 32'(rd_data), 32'h0161);
    pop();
`ifdef KB_BREAK_EVENT_EN
    chk("sp_brk", 32'(rd_data), 32'h8161);
    pop();
`endif
    chk("sp_empty_end", 32'(empty), 32'd1);
    pop();
    chk("sp_pop_empty", 32'(count), 32'd0);

    // direct key change
    flags = 5'h00;
    ascii = 8'h61;
    step(3);
    ascii = 8'h62;
    step(2 + BRK);
    chk("kc_count", 32'(count), 32'(2 + BRK));
    chk("kc_head0", 32'(rd_data), 32'h0061);
    pop();
`ifdef KB_BREAK_EVENT_EN
    chk("kc_brk", 32'(rd_data), 32'h8061);
    pop();
`endif
    chk("kc_head1", 32'(rd_data), 32'h0062);
    step(8 - BRK);
    chk("kc_no_early", 32'(count), 32'd1);
    step(1);
    chk("kc_rep", 32'(count), 32'd2);
    ascii = 8'h00;
    step(3);
    drain();
    chk("kc_drain", 32'(count), 32'd0);

    // typematic overrun
    ascii = 8'h41;
    step(30);
    ascii = 8'h00;
    step(3);
    chk("tm_count", 32'(count), 32'd4);
    chk("tm_ovf", 32'(overflow), 32'd1);
    chk("tm_head", 32'(rd_data), 32'h0041);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("tm_ovf_clr", 32'(overflow), 32'd0);
    drain();
    chk("tm_drain", 32'(count), 32'd0);

    // full FIFO: pop coincides with repeat push
    ascii = 8'h41;
    flags = 5'h01;
    step(5);
    flags = 5'h02;
    step(9);
    flags = 5'h04;
    step(4);
    flags = 5'h08;
    step(4);
    flags = 5'h10;
    step(1);
    chk("fp_full", 32'(count), 32'd4);
    chk("fp_head0", 32'(rd_data), 32'h0141);
    pop();
    chk("fp_count", 32'(count), 32'd4);
    chk("fp_ovf", 32'(overflow), 32'd0);
    chk("fp_head1", 32'(rd_data), 32'h0241);
    ascii = 8'h00;
    pop();
    chk("fp_head2", 32'(rd_data), 32'h0441);
    step(3);
    drain();
    chk("fp_drain", 32'(count), 32'd0);

`ifdef KB_BREAK_EVENT_EN
    flags = 5'h00;
    ascii = 8'h61;
    step(4);
    ascii = 8'h00;
    step(3);
    chk("bk_count", 32'(count), 32'd2);
    chk("bk_make", 32'(rd_data), 32'h0061);
    pop();
    chk("bk_break", 32'(rd_data), 32'h8061);
    pop();
    pop();
    chk("bk_pop_empty", 32'(count), 32'd0);
`endif

    // asynchronous reset mid-run
    flags = 5'h00;
    ascii = 8'h33;
    step(17);
    chk("ar_pre", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_ovf", 32'(overflow), 32'd0);
    chk("ar_data", 32'(rd_data), 32'h0);
    ascii = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    chk("ar_after", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
